data_mem_store_buffer: RTL and testbench



---
 rtl/data_mem_store_buffer_pkg.sv | 23 ++
 rtl/data_mem_store_buffer_if.sv | 30 +++
 rtl/data_mem_store_buffer_sb_fifo.sv | 58 +++++
 rtl/data_mem_store_buffer.sv | 150 +++++++++++++++
 tb/tb_data_mem_store_buffer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_store_buffer_pkg.sv
// rtl/data_mem_store_buffer_pkg.sv - shared types and constants for the data_mem store buffer
package data_mem_store_buffer_pkg;

  typedef enum logic [0:0] {
    DMEM_IDLE = 1'b0,
    DMEM_BUSY = 1'b1
  } dmem_state_t;

  localparam logic [31:0] LED_ADDR  = 32'h0000_2000;
  localparam logic [31:0] DMEM_BASE = 32'h0000_1000;

  // One buffered store: 32-bit address, 32-bit data, 4-bit size/sign code (68 bits).
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sign_mask;
  } sb_entry_t;

  function automatic logic is_word(input logic [3:0] sign_mask);
    return sign_mask[2];
  endfunction

endpackage

// File: rtl/data_mem_store_buffer_if.sv
// rtl/data_mem_store_buffer_if.sv - pipeline-side and data_mem-side buses of the store buffer
interface sb_cpu_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        stall;

  modport master (output addr, write_data, memwrite, memread, sign_mask,
                  input  read_data, stall);
  modport slave  (input  addr, write_data, memwrite, memread, sign_mask,
                  output read_data, stall);
endinterface

interface sb_mem_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;

  modport master (output addr, write_data, memwrite, memread, sign_mask,
                  input  read_data, clk_stall);
  modport slave  (input  addr, write_data, memwrite, memread, sign_mask,
                  output read_data, clk_stall);
endinterface

// File: rtl/data_mem_store_buffer_sb_fifo.sv
// rtl/data_mem_store_buffer_sb_fifo.sv - DEPTH x 68-bit register FIFO with combinational head (STORE_FWD_EN exposes all slots)
module sb_fifo
  import data_mem_store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  sb_entry_t        push_entry,
  output sb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
`ifdef STORE_FWD_EN
  ,
  output sb_entry_t [DEPTH-1:0] slots,
  output logic [PTR_W-1:0]      rd_ptr
`endif
);

  sb_entry_t [DEPTH-1:0] slots_q;
  logic [PTR_W-1:0]      rd_q;
  logic [PTR_W-1:0]      wr_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      count <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) slots_q[wr_q] <= push_entry;
  end

  assign head  = slots_q[rd_q];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

`ifdef STORE_FWD_EN
  assign slots  = slots_q;
  assign rd_ptr = rd_q;
`endif

endmodule

// File: rtl/data_mem_store_buffer.sv
// rtl/data_mem_store_buffer.sv - posted-write store buffer between MEM stage and data_mem
// Optional store-to-load forwarding is built when STORE_FWD_EN is defined.
module data_mem_store_buffer
  import data_mem_store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  sb_cpu_if.slave        cpu,
  sb_mem_if.master       mem,
  output logic [PTR_W:0] count
);

  dmem_state_t state_q, state_d;
  logic        busy_load_q, seen_q, load_done_q;
  logic        memwrite_q, memread_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  mask_q;
  sb_entry_t   head, push_entry;
  logic        full, empty, push, pop;
  logic        store_req, load_pend, complete, issue_load, issue_store;
  logic        load_ready, fwd_hit;

`ifdef STORE_FWD_EN
  sb_entry_t [DEPTH-1:0] slots;
  logic [PTR_W-1:0]      rd_ptr, idx;
  logic                  fwd_match, fwd_word;
  logic [31:0]           fwd_data;
`endif

  assign store_req  = cpu.memwrite;
  assign load_pend  = cpu.memread && !cpu.memwrite && !load_done_q;
  // A completion requires the stall to have been seen high first, so the idle cycle right after the pulse is skipped.
  assign complete   = (state_q == DMEM_BUSY) && seen_q && !mem.clk_stall;
  assign pop        = complete && !busy_load_q;
  assign push       = store_req && (!full || pop);
  assign push_entry = {cpu.addr, cpu.write_data, cpu.sign_mask};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
`ifdef STORE_FWD_EN
    ,
    .slots      (slots),
    .rd_ptr     (rd_ptr)
`endif
  );

`ifdef STORE_FWD_EN
  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    fwd_match = 1'b0;
    fwd_word  = 1'b0;
    fwd_data  = '0;
    idx       = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (slots[idx].addr[31:2] == cpu.addr[31:2])) begin
        fwd_match = 1'b1;
        fwd_word  = is_word(slots[idx].sign_mask);
        fwd_data  = slots[idx].data;
      end
    end
  end
  assign fwd_hit    = load_pend && fwd_match && fwd_word && is_word(cpu.sign_mask);
  assign load_ready = fwd_match ? empty : 1'b1;
`else
  assign fwd_hit    = 1'b0;
  assign load_ready = empty;
`endif

  assign issue_load  = (state_q == DMEM_IDLE) && load_pend && load_ready && !fwd_hit;
  assign issue_store = (state_q == DMEM_IDLE) && !issue_load && !empty;

  assign cpu.stall     = rst_n && ((store_req && full && !pop) || load_pend);
  assign cpu.read_data = rdata_q;

  assign mem.addr       = addr_q;
  assign mem.write_data = wdata_q;
  assign mem.sign_mask  = mask_q;
  assign mem.memwrite   = memwrite_q;
  assign mem.memread    = memread_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DMEM_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DMEM_IDLE: if (issue_load || issue_store) state_d = DMEM_BUSY;
      DMEM_BUSY: if (complete) state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
      busy_load_q <= 1'b0;
      seen_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      memwrite_q  <= issue_store;
      memread_q   <= issue_load;
      load_done_q <= 1'b0;
      if (issue_load) begin
        addr_q      <= cpu.addr;
        mask_q      <= cpu.sign_mask;
        busy_load_q <= 1'b1;
        seen_q      <= 1'b0;
      end else if (issue_store) begin
        addr_q      <= head.addr;
        wdata_q     <= head.data;
        mask_q      <= head.sign_mask;
        busy_load_q <= 1'b0;
        seen_q      <= 1'b0;
      end else if ((state_q == DMEM_BUSY) && mem.clk_stall) begin
        seen_q <= 1'b1;
      end
      // load_done_q lowers cpu.stall for exactly the cycle in which the load is consumed.
      if (complete && busy_load_q) begin
        rdata_q     <= mem.read_data;
        load_done_q <= 1'b1;
      end
`ifdef STORE_FWD_EN
      if (fwd_hit) begin
        rdata_q     <= fwd_data;
        load_done_q <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_store_buffer.sv
// tb/tb_data_mem_store_buffer.sv - directed self-checking bench for data_mem_store_buffer
module tb_data_mem_store_buffer;
  import data_mem_store_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIM   = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] count;

  sb_cpu_if cpu ();
  sb_mem_if mem ();

  data_mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (cpu),
    .mem   (mem),
    .count (count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] wr_addrs [$];
  logic [3:0]  last_rd_mask = 4'h0;
  logic [31:0] dm [logic [29:0]];
  int          dm_lat = 1;
  int          dm_left = 0;
  logic        led = 1'b0;

  function automatic logic [31:0] dm_word(input logic [29:0] w);
    return dm.exists(w) ? dm[w] : 32'h0;
  endfunction

  // mask: bit3 = sign-extend, bits[2:0] = 100 word, 010 half, else byte
  task automatic dm_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = dm_word(a[31:2]);
    case (m[2:0])
      3'b100:  w = d;
      3'b010:  w[16*a[1] +: 16] = d[15:0];
      default: w[8*a[1:0] +: 8] = d[7:0];
    endcase
    dm[a[31:2]] = w;
    if (a == LED_ADDR) led = d[0];
  endtask

  function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = dm_word(a[31:2]);
    h = w[16*a[1] +: 16];
    b = w[8*a[1:0] +: 8];
    case (m[2:0])
      3'b100:  return w;
      3'b010:  return m[3] ? {{16{h[15]}}, h} : {16'h0, h};
      default: return m[3] ? {{24{b[7]}}, b} : {24'h0, b};
    endcase
  endfunction

  // data_mem model: samples a request pulse, then holds clk_stall for dm_lat cycles
  initial begin
    mem.clk_stall = 1'b0;
    mem.read_data = 32'h0;
    forever begin
      @(posedge clk);
      if (dm_left != 0) begin
        dm_left <= dm_left - 1;
        if (dm_left == 1) mem.clk_stall <= 1'b0;
      end else if (mem.memwrite || mem.memread) begin
        mem.clk_stall <= 1'b1;
        dm_left <= dm_lat;
        if (mem.memwrite) dm_write(mem.addr, mem.write_data, mem.sign_mask);
        else mem.read_data <= dm_read(mem.addr, mem.sign_mask);
      end
    end
  end

  always @(negedge clk) begin
    if (mem.memwrite) begin
      wr_cnt++;
      wr_addrs.push_back(mem.addr);
    end
    if (mem.memread) begin
      rd_cnt++;
      last_rd_mask = mem.sign_mask;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cpu_op(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, output int waits);
    @(negedge clk);
    cpu.addr = a;
    cpu.write_data = d;
    cpu.sign_mask = m;
    cpu.memwrite = wr;
    cpu.memread = rd;
    waits = 0;
    #1;
    while (cpu.stall && waits < LIM) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("stall_bound", 32'(waits >= LIM), 32'h0);
    @(posedge clk);
    #1;
    cpu.memwrite = 1'b0;
    cpu.memread = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (count != 0 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", 32'(n >= LIM), 32'h0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base_w;
    int base_r;
    cpu.addr = 32'h0;
    cpu.write_data = 32'h0;
    cpu.sign_mask = 4'h0;
    cpu.memwrite = 1'b0;
    cpu.memread = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'h0);
    check("rst_stall", 32'(cpu.stall), 32'h0);
    check("rst_memwrite", 32'(mem.memwrite), 32'h0);
    check("rst_memread", 32'(mem.memread), 32'h0);
    check("rst_addr", mem.addr, 32'h0);
    check("rst_read_data", cpu.read_data, 32'h0);
    rst_n = 1'b1;

    // single store, empty buffer
    base_w = wr_cnt;
    cpu_op(1'b1, 1'b0, 32'h4000, 32'h1122_3344, 4'b0100, w);
    check("t1_waits", 32'(w), 32'h0);
    check("t1_count_accept", 32'(count), 32'h1);
    check("t1_memwrite_e0", 32'(mem.memwrite), 32'h0);
    @(posedge clk); #1;
    check("t1_memwrite_e1", 32'(mem.memwrite), 32'h1);
    check("t1_addr", mem.addr, 32'h4000);
    check("t1_wdata", mem.write_data, 32'h1122_3344);
    @(posedge clk); #1;
    check("t1_memwrite_e2", 32'(mem.memwrite), 32'h0);
    check("t1_count_e2", 32'(count), 32'h1);
    @(posedge clk); #1;
    check("t1_count_e3", 32'(count), 32'h1);
    @(posedge clk); #1;
    check("t1_count_e4", 32'(count), 32'h0);
    wait_drain();
    check("t1_pulses", 32'(wr_cnt - base_w), 32'h1);

    // back-to-back stores overflow the 4-entry buffer
    dm_lat = 3;
    wr_addrs.delete();
    base_w = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      cpu_op(1'b1, 1'b0, 32'h4000 + 32'(4 * i), 32'hA0 + 32'(i), 4'b0100, w);
      check($sformatf("t2_waits_%0d", i), 32'(w), (i < 4) ? 32'h0 : 32'h2);
    end
    check("t2_count_full", 32'(count), 32'h4);
    wait_drain();
    dm_lat = 1;
    check("t2_pulses", 32'(wr_cnt - base_w), 32'h5);
    check("t2_order_len", 32'(wr_addrs.size()), 32'h5);
    for (int i = 0; i < 5 && i < wr_addrs.size(); i++)
      check($sformatf("t2_order_%0d", i), wr_addrs[i], 32'h4000 + 32'(4 * i));

    // load with empty buffer
    base_r = rd_cnt;
    cpu_op(1'b0, 1'b1, 32'h4004, 32'h0, 4'b0100, w);
    check("tl_latency", 32'(w), 32'h4);
    check("tl_data", cpu.read_data, 32'h0000_00A1);
    check("tl_reads", 32'(rd_cnt - base_r), 32'h1);

    // store then load of the same word
    base_r = rd_cnt;
    cpu_op(1'b1, 1'b0, 32'h4008, 32'hAABB_CCDD, 4'b0100, w);
    check("t3_store_waits", 32'(w), 32'h0);
    cpu_op(1'b0, 1'b1, 32'h4008, 32'h0, 4'b0100, w);
    check("t3_load_waits", 32'(w), 32'h8);
    check("t3_data", cpu.read_data, 32'hAABB_CCDD);
    check("t3_reads", 32'(rd_cnt - base_r), 32'h1);
    check("t3_count", 32'(count), 32'h0);

    // byte store, signed/unsigned byte and signed half loads
    cpu_op(1'b1, 1'b0, 32'h4009, 32'h0000_0080, 4'b0000, w);
    cpu_op(1'b0, 1'b1, 32'h4009, 32'h0, 4'b1000, w);
    check("t4_lb", cpu.read_data, 32'hFFFF_FF80);
    check("t4_mask", 32'(last_rd_mask), 32'h8);
    wait_drain();
    cpu_op(1'b0, 1'b1, 32'h4009, 32'h0, 4'b0000, w);
    check("t4_lbu_waits", 32'(w), 32'h4);
    check("t4_lbu", cpu.read_data, 32'h0000_0080);
    cpu_op(1'b0, 1'b1, 32'h400A, 32'h0, 4'b1010, w);
    check("t4_lh", cpu.read_data, 32'hFFFF_AABB);
    check("t4_lh_mask", 32'(last_rd_mask), 32'hA);

    // LED store queued behind three others
    wr_addrs.delete();
    cpu_op(1'b1, 1'b0, 32'h4000, 32'h1, 4'b0100, w);
    cpu_op(1'b1, 1'b0, 32'h4004, 32'h2, 4'b0100, w);
    cpu_op(1'b1, 1'b0, 32'h400C, 32'h3, 4'b0100, w);
    cpu_op(1'b1, 1'b0, 32'h2000, 32'h1, 4'b0100, w);
    check("t5_led_waits", 32'(w), 32'h0);
    check("t5_led_early", 32'(led), 32'h0);
    wait_drain();
    check("t5_len", 32'(wr_addrs.size()), 32'h4);
    check("t5_third", wr_addrs[2], 32'h400C);
    check("t5_led_addr", wr_addrs[3], 32'h2000);
    check("t5_led_late", 32'(led), 32'h1);

    // reset while busy with two entries queued
    dm_lat = 3;
    cpu_op(1'b1, 1'b0, 32'h4010, 32'h55, 4'b0100, w);
    cpu_op(1'b1, 1'b0, 32'h4014, 32'h66, 4'b0100, w);
    check("t6_busy_memwrite", 32'(mem.memwrite), 32'h1);
    check("t6_busy_count", 32'(count), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(count), 32'h0);
    check("t6_rst_memwrite", 32'(mem.memwrite), 32'h0);
    check("t6_rst_stall", 32'(cpu.stall), 32'h0);
    check("t6_rst_addr", mem.addr, 32'h0);
    base_w = wr_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_writes", 32'(wr_cnt - base_w), 32'h0);
    check("t6_count_after", 32'(count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
